// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, round constants, FSM state type and the schedule sigma functions.
`ifndef SHA256_ROTR
`define SHA256_ROTR(x, n) (((x) >> (n)) | ((x) << (32 - (n))))
`endif

package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned ROUNDS = 64;
    localparam int unsigned WIN    = 16;

    typedef enum logic [0:0] {StIdle, StRun} sched_state_e;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t s0(input word_t x);
        return `SHA256_ROTR(x, 7) ^ `SHA256_ROTR(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t s1(input word_t x);
        return `SHA256_ROTR(x, 17) ^ `SHA256_ROTR(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_sched_word.sv
// Combinational SHA-256 schedule word: W[t] from W[t-16], W[t-15], W[t-7], W[t-2].
module sha256_sched_word
    import sha256_pkg::*;
(
    input  word_t w0,
    input  word_t w1,
    input  word_t w9,
    input  word_t w14,
    output word_t w_new
);

    assign w_new = s1(w14) + w9 + s0(w1) + w0;

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: streams W[0..63] from a 16-word sliding window.
// Define SHA256_MSCHED_KOUT_EN to add the k_out port carrying K[w_idx].
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned IDX_W  = $clog2(ROUNDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [511:0]     blk_data,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [31:0]      w_out,
    output logic [IDX_W-1:0] w_idx,
    output logic             w_last
`ifdef SHA256_MSCHED_KOUT_EN
    ,
    output logic [31:0]      k_out
`endif
);

    if (ROUNDS != 64) begin : g_bad_rounds
        $error("sha256_msg_sched: only ROUNDS == 64 is supported");
    end

    sched_state_e     state_q;
    word_t            win_q [WIN];
    logic [IDX_W-1:0] idx_q;
    word_t            w_new;
    logic             w_acc;
    logic             blk_acc;

    assign w_valid   = (state_q == StRun);
    assign w_out     = win_q[0];
    assign w_idx     = idx_q;
    assign w_last    = w_valid && (idx_q == IDX_W'(ROUNDS - 1));
    assign w_acc     = w_valid && w_ready;
    // A block may land in the same cycle the last word leaves: zero-bubble reload.
    assign blk_ready = (state_q == StIdle) || (w_acc && w_last);
    assign blk_acc   = blk_valid && blk_ready;

    sha256_sched_word u_word (
        .w0   (win_q[0]),
        .w1   (win_q[1]),
        .w9   (win_q[9]),
        .w14  (win_q[14]),
        .w_new(w_new)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            for (int i = 0; i < WIN; i++) win_q[i] <= '0;
        end else if (blk_acc) begin
            state_q <= StRun;
            idx_q   <= '0;
            for (int j = 0; j < WIN; j++) win_q[j] <= blk_data[511 - 32*j -: 32];
        end else if (w_acc) begin
            if (w_last) begin
                // Window left untouched so w_out holds the final word while idle.
                state_q <= StIdle;
            end else begin
                for (int i = 0; i < WIN - 1; i++) win_q[i] <= win_q[i+1];
                win_q[WIN-1] <= w_new;
                idx_q        <= idx_q + 1'b1;
            end
        end
    end

`ifdef SHA256_MSCHED_KOUT_EN
    word_t k_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q <= '0;
        end else if (blk_acc) begin
            k_q <= K[0];
        end else if (w_acc) begin
            k_q <= w_last ? '0 : K[idx_q + 1'b1];
        end
    end

    assign k_out = k_q;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched against a full 64-word schedule model.
module tb_sha256_msg_sched;

    logic         clk;
    logic         rst_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;
    logic         w_last;
`ifdef SHA256_MSCHED_KOUT_EN
    logic [31:0]  k_out;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_w [64];

    sha256_msg_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .blk_valid(blk_valid),
        .blk_ready(blk_ready),
        .blk_data (blk_data),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_out    (w_out),
        .w_idx    (w_idx),
        .w_last   (w_last)
`ifdef SHA256_MSCHED_KOUT_EN
        ,
        .k_out    (k_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    // Textbook schedule expansion over the whole 64-entry array.
    task automatic build(input logic [511:0] blk);
        for (int t = 0; t < 16; t++) exp_w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            exp_w[t] = sig1(exp_w[t-2]) + exp_w[t-7] + sig0(exp_w[t-15]) + exp_w[t-16];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    task automatic load(input logic [511:0] blk);
        check("idle_blk_ready", 32'(blk_ready), 32'd1);
        check("idle_w_valid", 32'(w_valid), 32'd0);
        build(blk);
        blk_data  = blk;
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        blk_data  = rand_blk();
    endtask

    // Walks the 64 beats of the current block; optional stall, abort or chained next block.
    task automatic stream(input int stall_at, input int stall_len, input int abort_at,
                          input bit chain, input bit is_abc);
        for (int t = 0; t < 64; t++) begin
            if (t == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_w_valid", 32'(w_valid), 32'd0);
                check("abort_blk_ready", 32'(blk_ready), 32'd1);
                check("abort_w_idx", 32'(w_idx), 32'd0);
                check("abort_w_out", w_out, 32'd0);
                return;
            end
            if (t == stall_at) begin
                w_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check("stall_w_valid", 32'(w_valid), 32'd1);
                    check("stall_w_idx", 32'(w_idx), 32'(t));
                    check("stall_w_out", w_out, exp_w[t]);
                    check("stall_blk_ready", 32'(blk_ready), 32'd0);
                    tick();
                end
                w_ready = 1'b1;
            end
            check("w_valid", 32'(w_valid), 32'd1);
            check("w_idx", 32'(w_idx), 32'(t));
            check("w_out", w_out, exp_w[t]);
            check("w_last", 32'(w_last), 32'(t == 63));
            check("run_blk_ready", 32'(blk_ready), 32'(t == 63));
            if (is_abc && t == 16) check("abc_w16", w_out, 32'h61626380);
            if (is_abc && t == 17) check("abc_w17", w_out, 32'h000f0000);
            if (is_abc && t == 18) check("abc_w18", w_out, 32'h7da86405);
`ifdef SHA256_MSCHED_KOUT_EN
            if (t == 0)  check("k_out_0", k_out, 32'h428a2f98);
            if (t == 63) check("k_out_63", k_out, 32'hc67178f2);
`endif
            tick();
        end
        blk_valid = 1'b0;
        if (!chain) begin
            for (int r = 0; r < 2; r++) begin
                check("done_w_valid", 32'(w_valid), 32'd0);
                check("done_blk_ready", 32'(blk_ready), 32'd1);
                check("done_w_out_hold", w_out, exp_w[63]);
`ifdef SHA256_MSCHED_KOUT_EN
                check("done_k_out", k_out, 32'd0);
`endif
                tick();
            end
        end
    endtask

    initial begin
        logic [511:0] abc;
        logic [511:0] blk_b;

        rst_n     = 1'b0;
        blk_valid = 1'b0;
        blk_data  = '0;
        w_ready   = 1'b1;
        #12;
        check("rst_w_valid", 32'(w_valid), 32'd0);
        check("rst_w_idx", 32'(w_idx), 32'd0);
        check("rst_w_out", w_out, 32'd0);
        check("rst_blk_ready", 32'(blk_ready), 32'd1);
`ifdef SHA256_MSCHED_KOUT_EN
        check("rst_k_out", k_out, 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Padded "abc", full-rate consumer.
        abc = '0;
        abc[511 -: 32] = 32'h61626380;
        abc[31:0]      = 32'h00000018;
        load(abc);
        stream(-1, 0, -1, 1'b0, 1'b1);

        // Random block with a five-cycle stall at idx 20.
        load(rand_blk());
        stream(20, 5, -1, 1'b0, 1'b0);

        // Block B offered throughout A; accepted only on A's last beat.
        load(rand_blk());
        blk_b     = rand_blk();
        blk_data  = blk_b;
        blk_valid = 1'b1;
        stream(-1, 0, -1, 1'b1, 1'b0);
        build(blk_b);
        stream(-1, 0, -1, 1'b0, 1'b0);

        // Reset in the middle of a block, then a fresh block.
        load(rand_blk());
        stream(-1, 0, 30, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        load(rand_blk());
        stream(-1, 0, -1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
